byte_serial_add_seq: RTL and testbench
======================================

Name: byte_serial_add_seq

Overview:
- Sequencer directly upstream of the 8-bit `cla` adder; also consumes the adder's sum/carry outputs.
- Accepts a WIDTH-bit operand pair plus carry-in over a valid/ready handshake.
- Presents one byte pair per cycle to the `cla` instance, least-significant byte first, and registers the inter-byte carry.
- Assembles the WIDTH-bit result, carry-out and signed-overflow flag, then offers them downstream over a second valid/ready handshake.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of 8 and at least 8.
- NBYTES, WIDTH/8, derived localparam; number of adder passes.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- op_a  input  WIDTH  operand A.
- op_b  input  WIDTH  operand B.
- op_cin  input  1  carry into byte 0.
- cla_a  output  8  byte of A driven to the adder.
- cla_b  output  8  byte of B driven to the adder.
- cla_cin  output  1  carry driven to the adder.
- cla_sum  input  8  adder sum, combinational from cla_a/cla_b/cla_cin.
- cla_cout  input  1  adder carry-out.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- result  output  WIDTH  assembled sum.
- cout  output  1  carry out of the MSB.
- ovf  output  1  two's-complement overflow.

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rst is synchronous and active-high.
- Reset (rst=1 at an edge) takes effect at that edge, including mid-operation. After reset:
  - state=IDLE, byte index=0, carry reg=0;
  - result=0, cout=0, ovf=0, out_valid=0, in_ready=1;
  - cla_a=0, cla_b=0, cla_cin=0;
  - any in-flight operation is discarded.
- States:
  - IDLE: in_ready=1. When in_valid=1 at an edge, latch op_a, op_b and op_cin; set carry reg=op_cin and idx=0; go to ADD.
  - ADD: in_ready=0.
    - Drive cla_a=A[8*idx+:8], cla_b=B[8*idx+:8] and cla_cin=carry reg.
    - At each edge, write cla_sum into result[8*idx+:8], set carry reg=cla_cout and increment idx.
    - When idx=NBYTES-1 at the edge: cout<=cla_cout, ovf<=(A[MSB]==B[MSB]) && (cla_sum[7]!=A[MSB]), then go to DONE.
  - DONE: out_valid=1 and in_ready=0. result, cout and ovf are held stable. When out_ready=1 at an edge, go to IDLE and deassert out_valid.
- Outside ADD, cla_a, cla_b and cla_cin are driven to 0.
- Latency:
  - Acceptance edge E; byte k is presented in the cycle after E+k.
  - out_valid rises after edge E+NBYTES, i.e. NBYTES+1 cycles after acceptance.
  - Throughput is one operation per NBYTES+2 cycles when out_ready is held high.
- Back-to-back: in_ready returns only in IDLE. No skid buffer; the upstream must hold in_valid and operands until accepted.
- result is updated byte-wise during ADD. Consumers may sample it only while out_valid=1.
- All arithmetic is modulo 2^WIDTH; the carry beyond the MSB appears only on cout.
- in_valid in states other than IDLE is ignored.
- out_ready outside DONE is ignored.
- WIDTH=8 degenerates to a single ADD cycle.

Test Plan:
- Carry across bytes: A=0x000000FF, B=0x00000001, cin=0 → result=0x00000100, cout=0, ovf=0; out_valid 5 cycles after acceptance.
- Full carry ripple: A=0xFFFFFFFF, B=0x00000000, cin=1 → result=0x00000000, cout=1, ovf=0; cla_cin=1 in each of the 4 ADD cycles.
- Signed overflow: A=0x7FFFFFFF, B=0x00000001, cin=0 → result=0x80000000, cout=0, ovf=1. Also A=0x80000000, B=0x80000000 → result=0, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 6 cycles after out_valid → result, cout and ovf stable and in_ready=0 throughout; raise out_ready → out_valid=0 and in_ready=1 on the next cycle.
- Reset mid-operation: assert rst for 1 cycle during the 2nd ADD cycle → next cycle all outputs are 0 and in_ready=1; a following operation 0x12345678+0x11111111 gives 0x23456789, cout=0.
- Random back-to-back: 1000 random operand/cin triples with a random out_ready duty cycle → each result equals {cout,result}=A+B+cin against a reference model; no transaction is lost or duplicated.

Source files
------------

// File: rtl/byte_serial_add_seq.sv
// Byte-serial adder sequencer.
// Accepts a WIDTH-bit operand pair plus carry-in, feeds one byte pair per cycle
// to an external 8-bit carry-lookahead adder (least-significant byte first),
// chains the inter-byte carry through a register, and assembles the full sum,
// carry-out and signed-overflow flag for a downstream valid/ready consumer.
// WIDTH must be a non-zero multiple of 8.

module byte_serial_add_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
  output logic [7:0]       cla_a,
  output logic [7:0]       cla_b,
  output logic             cla_cin,
  input  logic [7:0]       cla_sum,
  input  logic             cla_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int NBYTES = WIDTH / 8;
  localparam int IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t            r_state;
  state_t            w_nextState;

  logic [IDXW-1:0]   r_idx;
  logic              r_carry;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_result;
  logic              r_cout;
  logic              r_ovf;

  logic              w_accept;
  logic              w_lastByte;
  logic              w_inAdd;
  logic [7:0]        w_byteA;
  logic [7:0]        w_byteB;
  logic              w_ovfNext;

  assign w_inAdd    = (r_state == ADD);
  assign w_accept   = (r_state == IDLE) && in_valid;
  assign w_lastByte = w_inAdd && (r_idx == LAST_IDX);

  // Overflow: same-sign operands whose top result byte flips the sign bit.
  assign w_ovfNext = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (cla_sum[7] != r_a[WIDTH-1]);

  // Select the operand bytes addressed by the current byte index.
  always_comb begin
    w_byteA = '0;
    w_byteB = '0;
    for (int k = 0; k < NBYTES; k++) begin
      if (r_idx == IDXW'(k)) begin
        w_byteA = r_a[8*k +: 8];
        w_byteB = r_b[8*k +: 8];
      end
    end
  end

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic and handshake/adder-interface outputs.
  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    cla_a       = 8'h00;
    cla_b       = 8'h00;
    cla_cin     = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_nextState = ADD;
        end
      end
      ADD: begin
        cla_a   = w_byteA;
        cla_b   = w_byteB;
        cla_cin = r_carry;
        if (r_idx == LAST_IDX) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Operand capture, byte-wise result assembly and carry chaining.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_a     <= op_a;
      r_b     <= op_b;
      r_carry <= op_cin;
      r_idx   <= '0;
    end else if (w_inAdd) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (r_idx == IDXW'(k)) begin
          r_result[8*k +: 8] <= cla_sum;
        end
      end
      r_carry <= cla_cout;
      if (w_lastByte) begin
        r_cout <= cla_cout;
        r_ovf  <= w_ovfNext;
        r_idx  <= '0;
      end else begin
        r_idx  <= r_idx + IDXW'(1);
      end
    end
  end

  assign result = r_result;
  assign cout   = r_cout;
  assign ovf    = r_ovf;

endmodule

// File: tb/tb_byte_serial_add_seq.sv
// Self-checking bench for byte_serial_add_seq with a behavioural 8-bit adder
// attached to the cla_* port pair. Directed table, multi-cycle corner cases
// and a randomized back-to-back run against an arithmetic reference model.

module tb_byte_serial_add_seq;

  localparam int WIDTH  = 32;
  localparam int NBYTES = WIDTH / 8;
  localparam int NRAND  = 1000;

  typedef longint unsigned u64_t;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] expRes;
    logic             expCout;
    logic             expOvf;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
  } op_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic [7:0]       cla_a;
  logic [7:0]       cla_b;
  logic             cla_cin;
  logic [7:0]       cla_sum;
  logic             cla_cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;

  int compared   = 0;
  int mismatched = 0;

  vec_t             vecs[6];
  op_t              pend[$];
  op_t              e;
  int               lat;
  logic [NBYTES-1:0] cinSeen;
  logic [WIDTH-1:0] aSeen;
  logic [WIDTH-1:0] bSeen;
  bit               ok;
  int               sent;
  int               got;
  int               cyc;
  bit               acceptPending;
  logic [WIDTH-1:0] mRes;
  logic             mCout;

  byte_serial_add_seq #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op_a     (op_a),
    .op_b     (op_b),
    .op_cin   (op_cin),
    .cla_a    (cla_a),
    .cla_b    (cla_b),
    .cla_cin  (cla_cin),
    .cla_sum  (cla_sum),
    .cla_cout (cla_cout),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .cout     (cout),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the 8-bit cla adder.
  assign {cla_cout, cla_sum} = {1'b0, cla_a} + {1'b0, cla_b} + {8'h00, cla_cin};

  // Watchdog so the bench can never hang.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [WIDTH:0] modelSum(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
    u64_t full;
    full = u64_t'(a) + u64_t'(b) + u64_t'(cin);
    return full[WIDTH:0];
  endfunction

  function automatic logic modelOvf(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
    longint sa;
    longint sb;
    longint s;
    longint maxv;
    longint minv;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    s    = sa + sb + longint'(cin);
    maxv = (longint'(1) <<< (WIDTH - 1)) - 1;
    minv = -(longint'(1) <<< (WIDTH - 1));
    return (s > maxv) || (s < minv);
  endfunction

  function automatic logic [NBYTES-1:0] modelCarries(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
    logic [NBYTES-1:0] c;
    u64_t m;
    u64_t s;
    c = '0;
    for (int k = 0; k < NBYTES; k++) begin
      m = (u64_t'(1) << (8 * k)) - 1;
      s = (u64_t'(a) & m) + (u64_t'(b) & m) + u64_t'(cin);
      c[k] = ((s >> (8 * k)) != 0);
    end
    return c;
  endfunction

  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                               output int latency, output logic [NBYTES-1:0] cinObs,
                               output logic [WIDTH-1:0] aObs, output logic [WIDTH-1:0] bObs,
                               output bit done);
    int waitCyc;
    latency = 0;
    cinObs  = '0;
    aObs    = '0;
    bObs    = '0;
    done    = 1'b0;
    @(negedge clk);
    op_a     = a;
    op_b     = b;
    op_cin   = cin;
    in_valid = 1'b1;
    waitCyc  = 0;
    while (!in_ready && waitCyc < 50) begin
      @(negedge clk);
      waitCyc++;
    end
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    op_a     = ~a;
    op_b     = ~b;
    op_cin   = ~cin;
    latency  = 1;
    while (!out_valid && latency <= NBYTES + 10) begin
      if (latency <= NBYTES) begin
        cinObs[latency-1]          = cla_cin;
        aObs[8*(latency-1) +: 8]   = cla_a;
        bObs[8*(latency-1) +: 8]   = cla_b;
      end
      @(negedge clk);
      latency++;
    end
    done = out_valid;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    op_cin    = 1'b0;
    out_ready = 1'b0;

    vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
    vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[3] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vecs[4] = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0};
    vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_ready_valid", {in_ready, out_valid}, {1'b1, 1'b0});
    checkOutput("reset_result", {cout, ovf, result}, '0);
    checkOutput("reset_cla", {cla_cin, cla_a, cla_b}, '0);

    $display("[TB] directed table");
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, lat, cinSeen, aSeen, bSeen, ok);
      checkOutput($sformatf("vec%0d_done", i), ok, 1'b1);
      checkOutput($sformatf("vec%0d_latency", i), lat, NBYTES + 1);
      checkOutput($sformatf("vec%0d_result", i), result, vecs[i].expRes);
      checkOutput($sformatf("vec%0d_cout", i), cout, vecs[i].expCout);
      checkOutput($sformatf("vec%0d_ovf", i), ovf, vecs[i].expOvf);
      checkOutput($sformatf("vec%0d_cla_cin", i), cinSeen, modelCarries(vecs[i].a, vecs[i].b, vecs[i].cin));
      checkOutput($sformatf("vec%0d_cla_a", i), aSeen, vecs[i].a);
      checkOutput($sformatf("vec%0d_cla_b", i), bSeen, vecs[i].b);
    end

    $display("[TB] backpressure");
    @(negedge clk);
    out_ready = 1'b0;
    applyStimulus(32'h0F0F0F0F, 32'h01010101, 1'b1, lat, cinSeen, aSeen, bSeen, ok);
    checkOutput("bp_done", ok, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("bp_hold", {out_valid, in_ready, cout, ovf, result},
                  {1'b1, 1'b0, 1'b0, 1'b0, 32'h10101011});
    end
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release", {out_valid, in_ready}, {1'b0, 1'b1});

    $display("[TB] reset mid-operation");
    op_a     = 32'hA5A5A5A5;
    op_b     = 32'h5A5A5A5B;
    op_cin   = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_ready_valid", {in_ready, out_valid}, {1'b1, 1'b0});
    checkOutput("midrst_result", {cout, ovf, result}, '0);
    checkOutput("midrst_cla", {cla_cin, cla_a, cla_b}, '0);
    applyStimulus(32'h12345678, 32'h11111111, 1'b0, lat, cinSeen, aSeen, bSeen, ok);
    checkOutput("midrst_after_done", ok, 1'b1);
    checkOutput("midrst_after_latency", lat, NBYTES + 1);
    checkOutput("midrst_after_sum", {cout, result}, {1'b0, 32'h23456789});

    $display("[TB] random back-to-back");
    @(negedge clk);
    out_ready     = 1'b0;
    in_valid      = 1'b0;
    sent          = 0;
    got           = 0;
    cyc           = 0;
    acceptPending = 1'b0;
    while (got < NRAND && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      out_ready = ($urandom_range(0, 3) != 0);
      if (out_valid && out_ready) begin
        checkOutput("rand_queue_nonempty", pend.size() != 0, 1'b1);
        if (pend.size() != 0) begin
          e = pend.pop_front();
          {mCout, mRes} = modelSum(e.a, e.b, e.cin);
          checkOutput($sformatf("rand%0d_sum", got), {cout, result}, {mCout, mRes});
          checkOutput($sformatf("rand%0d_ovf", got), ovf, modelOvf(e.a, e.b, e.cin));
        end
        got++;
      end
      if (acceptPending) begin
        in_valid      = 1'b0;
        acceptPending = 1'b0;
      end
      if (!in_valid && sent < NRAND && $urandom_range(0, 2) != 0) begin
        op_a   = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : WIDTH'($urandom);
        op_b   = ($urandom_range(0, 7) == 0) ? 32'h80000000 : WIDTH'($urandom);
        op_cin = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
      end
      if (in_valid && in_ready) begin
        pend.push_back('{op_a, op_b, op_cin});
        sent++;
        acceptPending = 1'b1;
      end
    end
    in_valid = 1'b0;
    checkOutput("rand_all_returned", got, NRAND);
    checkOutput("rand_all_sent", sent, NRAND);
    checkOutput("rand_none_left", pend.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
